fd_stage: RTL and testbench

- IF/ID pipeline register and decode-stage branch resolver for the 5-stage MIPS pipeline.
- Captures IR_F, pc_F and pc4_F from the fetch stage each cycle.
- Decodes the held instruction into the next-PC controls that fetch consumes (pcsel, b, cmp_zero, equal, imm16, imm26, rs), using forwarded register values.
- Flags fetch address exceptions and carries them with the instruction.

---
 rtl/mips_defs_pkg.sv | 48 ++++
 rtl/fd_stage_br_decode.sv | 59 +++++
 rtl/fd_stage.sv | 112 +++++++++++
 tb/tb_fd_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants: opcodes, functs, REGIMM rt codes, next-PC and
// branch-type encodings, rs sign classes and the legal instruction-memory window.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_BLEZALS = 6'b111100;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [2:0] PCSEL_PC4 = 3'd0;
  localparam logic [2:0] PCSEL_BR  = 3'd1;
  localparam logic [2:0] PCSEL_J   = 3'd2;
  localparam logic [2:0] PCSEL_JR  = 3'd3;

  localparam logic [2:0] BR_NONE    = 3'd0;
  localparam logic [2:0] BR_BEQ     = 3'd1;
  localparam logic [2:0] BR_BNE     = 3'd2;
  localparam logic [2:0] BR_BLEZ    = 3'd3;
  localparam logic [2:0] BR_BGTZ    = 3'd4;
  localparam logic [2:0] BR_BLTZ    = 3'd5;
  localparam logic [2:0] BR_BGEZ    = 3'd6;
  localparam logic [2:0] BR_BLEZALS = 3'd7;

  localparam logic [1:0] CMPZ_ZERO = 2'b00;
  localparam logic [1:0] CMPZ_NEG  = 2'b01;
  localparam logic [1:0] CMPZ_POS  = 2'b10;

  localparam logic [31:0] IM_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_TOP_DEF  = 32'h0000_6FFC;

  function automatic logic [1:0] cmpz_of(input logic signed [31:0] v);
    if (v == 32'sd0)     return CMPZ_ZERO;
    else if (v < 32'sd0) return CMPZ_NEG;
    else                 return CMPZ_POS;
  endfunction

endpackage

// File: rtl/fd_stage_br_decode.sv
// Combinational decode of the D-stage instruction fields into next-PC select,
// branch type, rs sign class, rs/rt equality and the link request.
module br_decode
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rt_fld,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_fwd,
  input  logic [31:0] rt_fwd,
  output logic [2:0]  pcsel,
  output logic [2:0]  b,
  output logic [1:0]  cmp_zero,
  output logic        equal,
  output logic        link
);

  logic signed [31:0] rs_s;

  assign rs_s     = rs_fwd;
  assign cmp_zero = cmpz_of(rs_s);
  assign equal    = (rs_fwd == rt_fwd);

  always_comb begin
    pcsel = PCSEL_PC4;
    b     = BR_NONE;
    link  = 1'b0;
    unique case (op)
      OP_BEQ:  begin pcsel = PCSEL_BR; b = BR_BEQ;  end
      OP_BNE:  begin pcsel = PCSEL_BR; b = BR_BNE;  end
      OP_BLEZ: begin pcsel = PCSEL_BR; b = BR_BLEZ; end
      OP_BGTZ: begin pcsel = PCSEL_BR; b = BR_BGTZ; end
      OP_REGIMM: begin
        if (rt_fld == RT_BLTZ) begin
          pcsel = PCSEL_BR; b = BR_BLTZ;
        end else if (rt_fld == RT_BGEZ) begin
          pcsel = PCSEL_BR; b = BR_BGEZ;
        end
      end
      OP_J:   pcsel = PCSEL_J;
      OP_JAL: begin pcsel = PCSEL_J; link = 1'b1; end
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          pcsel = PCSEL_JR;
        end else if (funct == FN_JALR) begin
          pcsel = PCSEL_JR; link = 1'b1;
        end
      end
      // Links only on the taken path, which decode can see from rs already.
      OP_BLEZALS: begin
        pcsel = PCSEL_BR;
        b     = BR_BLEZALS;
        link  = (cmp_zero != CMPZ_POS);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fd_stage.sv
// IF/ID pipeline register with stall/flush priority and fetch-address (AdEL)
// checking; drives decode-stage next-PC controls back to fetch.
module fd_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_TOP   = IM_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] IR_F,
  input  logic [31:0] pc_F,
  input  logic [31:0] pc4_F,
  input  logic [31:0] rs_fwd,
  input  logic [31:0] rt_fwd,
  output logic [31:0] IR_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D,
  output logic        exc_D,
  output logic [2:0]  pcsel,
  output logic [2:0]  b,
  output logic [1:0]  cmp_zero,
  output logic        equal,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [31:0] rs,
  output logic        link_D
);

  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic        adel_f;

  assign adel_f = (pc_F[1:0] != 2'b00) || (pc_F < IM_BASE) || (pc_F > IM_TOP);

  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    exc_d   = exc_q;
    // Stall outranks flush: the held instruction must not be annulled.
    if (!stall) begin
      pc_d  = pc_F;
      pc4_d = pc4_F;
      if (flush) begin
        ir_d    = 32'h0;
        valid_d = 1'b0;
        exc_d   = 1'b0;
      end else begin
        ir_d    = adel_f ? 32'h0 : IR_F;
        valid_d = 1'b1;
        exc_d   = adel_f;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q    <= 32'h0;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
    end
  end

  logic [2:0] dec_pcsel, dec_b;
  logic       dec_link;
  logic       slot_live;

  br_decode u_br_decode (
    .op       (ir_q[31:26]),
    .rt_fld   (ir_q[20:16]),
    .funct    (ir_q[5:0]),
    .rs_fwd   (rs_fwd),
    .rt_fwd   (rt_fwd),
    .pcsel    (dec_pcsel),
    .b        (dec_b),
    .cmp_zero (cmp_zero),
    .equal    (equal),
    .link     (dec_link)
  );

  assign slot_live = valid_q && !exc_q;

  assign IR_D    = ir_q;
  assign pc_D    = pc_q;
  assign pc4_D   = pc4_q;
  assign valid_D = valid_q;
  assign exc_D   = exc_q;
  assign pcsel   = slot_live ? dec_pcsel : PCSEL_PC4;
  assign b       = slot_live ? dec_b : BR_NONE;
  assign link_D  = slot_live && dec_link;
  assign imm16   = ir_q[15:0];
  assign imm26   = ir_q[25:0];
  assign rs      = rs_fwd;

endmodule

// File: tb/tb_fd_stage.sv
// Scoreboard bench for fd_stage: directed vectors push expected D-stage state,
// a monitor pops and compares after each clock edge or reset assertion.
module tb_fd_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] IR_F = 32'h0;
  logic [31:0] pc_F = 32'h0000_3000;
  logic [31:0] pc4_F = 32'h0000_3004;
  logic [31:0] rs_fwd = 32'h0;
  logic [31:0] rt_fwd = 32'h0;
  logic [31:0] IR_D, pc_D, pc4_D, rs;
  logic        valid_D, exc_D, equal, link_D;
  logic [2:0]  pcsel, b;
  logic [1:0]  cmp_zero;
  logic [15:0] imm16;
  logic [25:0] imm26;

  fd_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .IR_F(IR_F), .pc_F(pc_F), .pc4_F(pc4_F), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
    .IR_D(IR_D), .pc_D(pc_D), .pc4_D(pc4_D), .valid_D(valid_D), .exc_D(exc_D),
    .pcsel(pcsel), .b(b), .cmp_zero(cmp_zero), .equal(equal),
    .imm16(imm16), .imm26(imm26), .rs(rs), .link_D(link_D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, pc, pc4, rs;
    logic        valid, exc, equal, link;
    logic [2:0]  pcsel, b;
    logic [1:0]  cmpz;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(string tag, logic [31:0] ir, logic [31:0] pc,
                              logic valid, logic exc, logic [2:0] ps, logic [2:0] bt,
                              logic [1:0] cz, logic eq, logic lk, logic [31:0] rsv);
    exp_t e;
    e.tag = tag; e.ir = ir; e.pc = pc; e.pc4 = pc + 32'd4; e.valid = valid;
    e.exc = exc; e.pcsel = ps; e.b = bt; e.cmpz = cz; e.equal = eq;
    e.link = lk; e.rs = rsv;
    return e;
  endfunction

  task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", tag, fld, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "IR_D",     IR_D,              e.ir);
        chk(e.tag, "pc_D",     pc_D,              e.pc);
        chk(e.tag, "pc4_D",    pc4_D,             e.pc4);
        chk(e.tag, "valid_D",  {31'h0, valid_D},  {31'h0, e.valid});
        chk(e.tag, "exc_D",    {31'h0, exc_D},    {31'h0, e.exc});
        chk(e.tag, "pcsel",    {29'h0, pcsel},    {29'h0, e.pcsel});
        chk(e.tag, "b",        {29'h0, b},        {29'h0, e.b});
        chk(e.tag, "cmp_zero", {30'h0, cmp_zero}, {30'h0, e.cmpz});
        chk(e.tag, "equal",    {31'h0, equal},    {31'h0, e.equal});
        chk(e.tag, "link_D",   {31'h0, link_D},   {31'h0, e.link});
        chk(e.tag, "imm16",    {16'h0, imm16},    {16'h0, e.ir[15:0]});
        chk(e.tag, "imm26",    {6'h0, imm26},     {6'h0, e.ir[25:0]});
        chk(e.tag, "rs",       rs,                e.rs);
      end
    end
  end

  task automatic step(logic st, logic fl, logic [31:0] ir, logic [31:0] pc,
                      logic [31:0] rsv, logic [31:0] rtv, exp_t e);
    stall = st; flush = fl; IR_F = ir; pc_F = pc; pc4_F = pc + 32'd4;
    rs_fwd = rsv; rt_fwd = rtv;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #2;
    exp_q.push_back(mk("por", 32'h0, 32'h3000, 0, 0, 0, 0, 2'b00, 1, 0, 32'h0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    step(0, 0, 32'h1000FFFF, 32'h3000, 32'h0, 32'h0,
         mk("beq0", 32'h1000FFFF, 32'h3000, 1, 0, 1, 1, 2'b00, 1, 0, 32'h0));

    #2;
    exp_q.push_back(mk("midrst", 32'h0, 32'h3000, 0, 0, 0, 0, 2'b00, 1, 0, 32'h0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    step(0, 0, 32'h10220003, 32'h3004, 32'd5, 32'd5,
         mk("beq", 32'h10220003, 32'h3004, 1, 0, 1, 1, 2'b10, 1, 0, 32'd5));
    step(1, 1, 32'h08000C00, 32'h3008, 32'd5, 32'd5,
         mk("stflush1", 32'h10220003, 32'h3004, 1, 0, 1, 1, 2'b10, 1, 0, 32'd5));
    step(1, 1, 32'h08000C04, 32'h300C, 32'd5, 32'd5,
         mk("stflush2", 32'h10220003, 32'h3004, 1, 0, 1, 1, 2'b10, 1, 0, 32'd5));
    step(0, 1, 32'h0C000C00, 32'h3010, 32'd5, 32'd5,
         mk("flush", 32'h0, 32'h3010, 0, 0, 0, 0, 2'b10, 1, 0, 32'd5));
    step(0, 0, 32'h0C000C10, 32'h3014, 32'h0, 32'h1,
         mk("jal", 32'h0C000C10, 32'h3014, 1, 0, 2, 0, 2'b00, 0, 1, 32'h0));
    step(0, 0, 32'h0C000C10, 32'h3002, 32'h0, 32'h0,
         mk("misalign", 32'h0, 32'h3002, 1, 1, 0, 0, 2'b00, 1, 0, 32'h0));
    step(0, 0, 32'h10220003, 32'h7000, 32'h0, 32'h0,
         mk("abovetop", 32'h0, 32'h7000, 1, 1, 0, 0, 2'b00, 1, 0, 32'h0));
    step(0, 0, 32'h0C000000, 32'h2FFC, 32'h0, 32'h0,
         mk("belowbase", 32'h0, 32'h2FFC, 1, 1, 0, 0, 2'b00, 1, 0, 32'h0));
    step(0, 0, 32'hF0200004, 32'h3020, 32'hFFFFFFFF, 32'h0,
         mk("blezals_n", 32'hF0200004, 32'h3020, 1, 0, 1, 7, 2'b01, 0, 1, 32'hFFFFFFFF));
    step(0, 0, 32'hF0200004, 32'h3024, 32'h1, 32'h0,
         mk("blezals_p", 32'hF0200004, 32'h3024, 1, 0, 1, 7, 2'b10, 0, 0, 32'h1));
    step(0, 0, 32'h00200008, 32'h3028, 32'h3040, 32'h3040,
         mk("jr", 32'h00200008, 32'h3028, 1, 0, 3, 0, 2'b10, 1, 0, 32'h3040));
    step(0, 0, 32'h0020F809, 32'h302C, 32'h3040, 32'h0,
         mk("jalr", 32'h0020F809, 32'h302C, 1, 0, 3, 0, 2'b10, 0, 1, 32'h3040));
    step(0, 0, 32'h04200002, 32'h3030, 32'h80000000, 32'h0,
         mk("bltz", 32'h04200002, 32'h3030, 1, 0, 1, 5, 2'b01, 0, 0, 32'h80000000));
    step(0, 0, 32'h04210002, 32'h3034, 32'd7, 32'd7,
         mk("bgez", 32'h04210002, 32'h3034, 1, 0, 1, 6, 2'b10, 1, 0, 32'd7));
    step(0, 0, 32'h14220002, 32'h3038, 32'd1, 32'd2,
         mk("bne", 32'h14220002, 32'h3038, 1, 0, 1, 2, 2'b10, 0, 0, 32'd1));
    step(0, 0, 32'h18200002, 32'h303C, 32'h0, 32'h0,
         mk("blez", 32'h18200002, 32'h303C, 1, 0, 1, 3, 2'b00, 1, 0, 32'h0));
    step(0, 0, 32'h1C200002, 32'h3040, 32'h0, 32'h0,
         mk("bgtz", 32'h1C200002, 32'h3040, 1, 0, 1, 4, 2'b00, 1, 0, 32'h0));
    step(0, 0, 32'hFC000000, 32'h3044, 32'h0, 32'h0,
         mk("unknown", 32'hFC000000, 32'h3044, 1, 0, 0, 0, 2'b00, 1, 0, 32'h0));
    step(0, 0, 32'h08000000, 32'h6FFC, 32'h0, 32'h0,
         mk("topedge", 32'h08000000, 32'h6FFC, 1, 0, 2, 0, 2'b00, 1, 0, 32'h0));

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout pending=%0d expected=0", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
